// File: rtl/zigzag_pkg.sv
// ----------------------------------------------------------------------------
// zigzag_pkg
//   Constants and types shared by the zigzag serializer and the unzigzag
//   reconstruction path:
//     ZZ_Q                - default signed coefficient width
//     ZZ_BLOCK_BUFF_SIZE  - coefficients per 8x8 block (64)
//     ZZ_LAST_IDX         - highest zigzag index (63)
//     ZZ_RC               - zigzag index -> {row[2:0], col[2:0]} table
//     zz_state_e          - serializer FSM state (EMPTY / STREAM)
//     zz_row / zz_col     - helpers that split a ZZ_RC entry
// ----------------------------------------------------------------------------
package zigzag_pkg;

   localparam int ZZ_Q               = 12;
   localparam int ZZ_BLOCK_BUFF_SIZE = 64;
   localparam int ZZ_LAST_IDX        = ZZ_BLOCK_BUFF_SIZE - 1;

   // Each entry is {row, col} packed as row*8+col. Entry k is the block
   // position emitted at zigzag index k; unzigzag writes beat k back to the
   // same position, so the two directions cannot drift apart.
   localparam logic [5:0] ZZ_RC [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic {
      ZZ_EMPTY  = 1'b0,
      ZZ_STREAM = 1'b1
   } zz_state_e;

   function automatic logic [2:0] zz_row(input logic [5:0] idx);
      logic [5:0] rc;
      rc = ZZ_RC[idx];
      return rc[5:3];
   endfunction

   function automatic logic [2:0] zz_col(input logic [5:0] idx);
      logic [5:0] rc;
      rc = ZZ_RC[idx];
      return rc[2:0];
   endfunction

endpackage

// File: rtl/zz_last_nz.sv
// ----------------------------------------------------------------------------
// zz_last_nz
//   Combinational scan of an 8x8 block in zigzag order. Reports the highest
//   zigzag index whose coefficient is nonzero, or flags that the whole block
//   is zero.
//   Ports:
//     i_block   in   [7:0][7:0][Q-1:0]  coefficients, [row][col]
//     o_last_nz out  6                  highest nonzero zigzag index
//     o_none    out  1                  1 when every coefficient is zero
// ----------------------------------------------------------------------------
module zz_last_nz
   import zigzag_pkg::*;
#(
   parameter int Q = ZZ_Q
) (
   input  logic [7:0][7:0][Q-1:0] i_block,
   output logic [5:0]             o_last_nz,
   output logic                   o_none
);

   // Ascending scan: a later nonzero hit overwrites an earlier one, so the
   // surviving value is the highest nonzero index.
   always_comb begin
      o_last_nz = '0;
      o_none    = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i_block[zz_row(6'(i))][zz_col(6'(i))] != '0) begin
            o_last_nz = 6'(i);
            o_none    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/zigzag_serializer.sv
// ----------------------------------------------------------------------------
// zigzag_serializer
//   Accepts a whole 8x8 coefficient block in one cycle and streams it out one
//   coefficient per beat in JPEG zigzag order, tagging each beat with its
//   zigzag index, an end-of-block flag and a "rest of block is zero" flag.
//
//   Handshakes (both ports): a transfer happens on a rising edge where
//   valid=1 and ready=1. The producer holds valid and payload steady until
//   the transfer; ready may change freely. in_ready additionally rises on the
//   final beat of a block so the next block follows with no bubble.
//
//   Ports:
//     clock          in   1                  rising-edge clock
//     reset_n        in   1                  asynchronous active-low reset
//     in_valid       in   1                  in_block holds a full block
//     in_ready       out  1                  block accepted this edge if valid
//     in_block       in   [7:0][7:0][Q-1:0]  signed coefficients, [row][col]
//     out_valid      out  1                  output beat valid
//     out_ready      in   1                  sink consumes current beat
//     out_coef       out  signed [Q-1:0]     current coefficient
//     out_idx        out  6                  zigzag index of out_coef
//     out_last       out  1                  out_idx == 63
//     out_tail_zero  out  1                  all later coefficients are zero
//     o_dbg_state    out  zz_state_e         FSM state for observation
// ----------------------------------------------------------------------------
module zigzag_serializer
   import zigzag_pkg::*;
#(
   parameter int Q     = ZZ_Q,
   // Only 64 coefficients per block are supported.
   parameter int NCOEF = ZZ_BLOCK_BUFF_SIZE
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [7:0][7:0][Q-1:0] in_block,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [Q-1:0]           out_coef,
   output logic [5:0]                    out_idx,
   output logic                          out_last,
   output logic                          out_tail_zero,
   output zz_state_e                     o_dbg_state
);

   localparam logic [5:0] LAST_IDX = 6'(NCOEF - 1);

   // Registered state: buffer, FSM state, current index, last-nonzero info.
   logic [7:0][7:0][Q-1:0] r_buf;
   zz_state_e              r_state;
   logic [5:0]             r_idx;
   logic [5:0]             r_last_nz;
   logic                   r_none;

   logic [5:0]             w_last_nz;
   logic                   w_none;
   logic                   w_at_last;
   logic                   w_beat;
   logic                   w_can_load;
   logic                   w_load;
   logic [2:0]             w_row;
   logic [2:0]             w_col;

   zz_last_nz #(
      .Q (Q)
   ) u_last_nz (
      .i_block   (in_block),
      .o_last_nz (w_last_nz),
      .o_none    (w_none)
   );

   assign w_at_last  = (r_idx == LAST_IDX);
   assign w_beat     = (r_state == ZZ_STREAM) & out_ready;
   // A new block may enter when nothing is held, or when the final beat of
   // the held block is consumed on this same edge.
   assign w_can_load = (r_state == ZZ_EMPTY) | (w_beat & w_at_last);
   assign w_load     = in_valid & w_can_load;

   // reset_n gates the port only; the FSM itself is held by the async reset,
   // so the buffer load enable does not need it.
   assign in_ready   = reset_n & w_can_load;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ZZ_EMPTY;
         r_idx     <= '0;
         r_last_nz <= '0;
         r_none    <= 1'b1;
      end else begin
         case (r_state)
            ZZ_EMPTY: begin
               if (w_load) begin
                  r_state   <= ZZ_STREAM;
                  r_idx     <= '0;
                  r_last_nz <= w_last_nz;
                  r_none    <= w_none;
               end
            end
            ZZ_STREAM: begin
               if (w_beat) begin
                  if (w_at_last) begin
                     r_idx <= '0;
                     if (w_load) begin
                        // Back-to-back: stay in STREAM on the new block.
                        r_last_nz <= w_last_nz;
                        r_none    <= w_none;
                     end else begin
                        r_state <= ZZ_EMPTY;
                     end
                  end else begin
                     r_idx <= r_idx + 6'd1;
                  end
               end
            end
            default: r_state <= ZZ_EMPTY;
         endcase
      end
   end

   // Datapath buffer: never cleared, outputs are masked while not streaming.
   always_ff @(posedge clock) begin
      if (w_load) begin
         r_buf <= in_block;
      end
   end

   assign w_row         = zz_row(r_idx);
   assign w_col         = zz_col(r_idx);

   assign out_valid     = (r_state == ZZ_STREAM);
   assign out_idx       = out_valid ? r_idx : 6'd0;
   assign out_last      = out_valid & w_at_last;
   assign out_coef      = out_valid ? r_buf[w_row][w_col] : '0;
   assign out_tail_zero = out_valid & (r_none | (r_idx >= r_last_nz));
   assign o_dbg_state   = r_state;

endmodule
